// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter for one fixed-latency memory port
// At most one transaction in flight; fetch is forced through after STARVE_MAX contended losses.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_owner, w_owner_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;

  logic w_done;
  logic w_arb;
  logic w_i_wins;

  assign w_done   = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_arb    = (r_state == ST_IDLE) || w_done;
  assign w_i_wins = i_req && (!d_req || (r_starve == STARVE_TOP));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_owner  <= OWN_I;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    // Reset masks every output, so an abandoned transaction never completes.
    if (!rst) begin
      if (w_done) begin
        w_state_nxt = ST_IDLE;
        if (r_owner == OWN_I) begin
          i_rvalid = 1'b1;
          i_rdata  = mem_rdata;
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
      end else if (r_state == ST_BUSY) begin
        w_cnt_nxt = r_cnt - CW'(1);
      end

      if (w_arb && w_i_wins) begin
        i_gnt        = 1'b1;
        mem_en       = 1'b1;
        mem_addr     = i_addr;
        w_owner_nxt  = OWN_I;
        w_starve_nxt = '0;
        w_state_nxt  = ST_BUSY;
        w_cnt_nxt    = CNT_INIT;
      end else if (w_arb && d_req) begin
        d_gnt       = 1'b1;
        mem_en      = 1'b1;
        mem_we      = d_we;
        mem_addr    = d_addr;
        mem_wdata   = d_wdata;
        w_owner_nxt = OWN_D;
        w_state_nxt = ST_BUSY;
        w_cnt_nxt   = CNT_INIT;
        if (i_req && (r_starve != STARVE_TOP)) begin
          w_starve_nxt = r_starve + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and sequence checks of mem_arbiter at several latencies
// Instances 0..4 run MEM_LAT = 2,1,4,3,8 on shared inputs; each check looks at one instance.
module tb_mem_arbiter;

  localparam int NI = 5;
  localparam logic [NI-1:0][3:0] LATS = {4'd8, 4'd3, 4'd4, 4'd1, 4'd2};

  logic        clk;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

  logic        i_gnt_a [NI];
  logic        i_rvalid_a [NI];
  logic [31:0] i_rdata_a [NI];
  logic        d_gnt_a [NI];
  logic        d_rvalid_a [NI];
  logic [31:0] d_rdata_a [NI];
  logic        mem_en_a [NI];
  logic        mem_we_a [NI];
  logic [31:0] mem_addr_a [NI];
  logic [31:0] mem_wdata_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.MEM_LAT(int'(LATS[g])), .STARVE_MAX(3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt_a[g]),
      .i_rvalid  (i_rvalid_a[g]),
      .i_rdata   (i_rdata_a[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt_a[g]),
      .d_rvalid  (d_rvalid_a[g]),
      .d_rdata   (d_rdata_a[g]),
      .mem_en    (mem_en_a[g]),
      .mem_we    (mem_we_a[g]),
      .mem_addr  (mem_addr_a[g]),
      .mem_wdata (mem_wdata_a[g]),
      .mem_rdata (mem_rdata)
    );
  end

  typedef struct packed {
    logic        i_gnt;
    logic        d_gnt;
    logic        i_rvalid;
    logic        d_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    outs_t       exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t ex(logic ig, logic dg, logic iv, logic dv, logic en, logic we,
                               logic [31:0] a, logic [31:0] w, logic [31:0] ir, logic [31:0] dr);
    outs_t o;
    o.i_gnt = ig; o.d_gnt = dg; o.i_rvalid = iv; o.d_rvalid = dv;
    o.mem_en = en; o.mem_we = we; o.mem_addr = a; o.mem_wdata = w;
    o.i_rdata = ir; o.d_rdata = dr;
    return o;
  endfunction

  function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dd, logic [31:0] mr, outs_t e);
    vec_t v;
    v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.mem_rdata = mr; v.exp = e;
    return v;
  endfunction

  function automatic outs_t grab(int k);
    outs_t o;
    o.i_gnt = i_gnt_a[k]; o.d_gnt = d_gnt_a[k];
    o.i_rvalid = i_rvalid_a[k]; o.d_rvalid = d_rvalid_a[k];
    o.mem_en = mem_en_a[k]; o.mem_we = mem_we_a[k];
    o.mem_addr = mem_addr_a[k]; o.mem_wdata = mem_wdata_a[k];
    o.i_rdata = i_rdata_a[k]; o.d_rdata = d_rdata_a[k];
    return o;
  endfunction

  task automatic chk(string nm, logic [133:0] act, logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  vec_t  tbl [17];
  outs_t z;
  outs_t e;
  int    k, lat;

  initial begin
    z = '0;
    tbl[0]  = mk(1, 1, 32'h100, 1, 0, 32'h40, 0, 0, z);
    tbl[1]  = mk(0, 1, 32'h100, 0, 1, 0, 32'hFFFFFFFF, 0, ex(1,0,0,0,1,0,32'h100,0,0,0));
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h11111111, z);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, ex(0,0,1,0,0,0,0,0,32'hDEADBEEF,0));
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, z);
    tbl[5]  = mk(0, 0, 0, 1, 1, 32'h40, 32'h12345678, 0, ex(0,1,0,0,1,1,32'h40,32'h12345678,0,0));
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAA5555, z);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, ex(0,0,0,1,0,0,0,0,0,32'hCAFEF00D));
    tbl[8]  = mk(0, 0, 0, 1, 0, 32'h80, 0, 0, ex(0,1,0,0,1,0,32'h80,0,0,0));
    tbl[9]  = mk(0, 1, 32'h200, 0, 0, 0, 0, 32'h55, z);
    tbl[10] = mk(0, 1, 32'h200, 0, 0, 0, 0, 32'h0BADF00D, ex(1,0,0,1,1,0,32'h200,0,0,32'h0BADF00D));
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h77, z);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h13579BDF, ex(0,0,1,0,0,0,0,0,32'h13579BDF,0));
    tbl[13] = mk(0, 0, 0, 1, 0, 32'h300, 0, 0, ex(0,1,0,0,1,0,32'h300,0,0,0));
    tbl[14] = mk(0, 1, 32'h400, 0, 0, 0, 0, 0, z);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h24681357, ex(0,0,0,1,0,0,0,0,0,32'h24681357));
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 32'h99, z);

    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;

    for (int r = 0; r < 17; r++) begin
      rst = tbl[r].rst; i_req = tbl[r].i_req; i_addr = tbl[r].i_addr;
      d_req = tbl[r].d_req; d_we = tbl[r].d_we; d_addr = tbl[r].d_addr;
      d_wdata = tbl[r].d_wdata; mem_rdata = tbl[r].mem_rdata;
      @(negedge clk);
      chk($sformatf("row%0d", r), grab(0), tbl[r].exp);
      tick();
    end

    // Continuous contention at MEM_LAT=2: grants every other cycle, pattern D,D,D,I.
    for (int c = 0; c < 16; c++) begin
      i_req = 1; i_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600;
      mem_rdata = 32'(c);
      @(negedge clk);
      if (c % 2 == 1)
        chk($sformatf("cont%0d", c), 134'({i_gnt_a[0], d_gnt_a[0]}), 134'(2'b00));
      else if ((c / 2) % 4 == 3)
        chk($sformatf("cont%0d", c), 134'({i_gnt_a[0], d_gnt_a[0]}), 134'(2'b10));
      else
        chk($sformatf("cont%0d", c), 134'({i_gnt_a[0], d_gnt_a[0]}), 134'(2'b01));
      tick();
    end

    // Back-to-back loads at MEM_LAT=1.
    do_reset();
    for (int b = 0; b < 5; b++) begin
      d_req = (b < 4); d_we = 0; d_addr = 32'h1000 + 32'(4 * b);
      mem_rdata = 32'hB0000000 + 32'(b);
      @(negedge clk);
      e = ex(b < 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      e.d_gnt = (b < 4); e.mem_en = (b < 4);
      e.mem_addr = (b < 4) ? d_addr : 32'h0;
      e.i_gnt = 1'b0;
      e.d_rvalid = (b > 0);
      e.d_rdata = (b > 0) ? mem_rdata : 32'h0;
      chk($sformatf("b2b%0d", b), grab(1), e);
      tick();
    end
    d_req = 0;

    // Reset one cycle after a data grant at MEM_LAT=4.
    do_reset();
    d_req = 1; d_addr = 32'h2000;
    @(negedge clk);
    chk("rmo_gnt", grab(2), ex(0,1,0,0,1,0,32'h2000,0,0,0));
    tick();
    d_req = 0; rst = 1; i_req = 1; i_addr = 32'h3000; mem_rdata = 32'hFFFFFFFF;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk($sformatf("rmo_rst%0d", t), grab(2), z);
      tick();
    end
    rst = 0;
    @(negedge clk);
    chk("rmo_regnt", grab(2), ex(1,0,0,0,1,0,32'h3000,0,0,0));
    tick();
    i_req = 0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      e = z;
      if (t == 4) begin
        e.i_rvalid = 1'b1;
        e.i_rdata = 32'hFFFFFFFF;
      end
      chk($sformatf("rmo_t%0d", t), grab(2), e);
      tick();
    end

    // Latency sweep on instances with MEM_LAT 1, 3, 8.
    for (int s = 0; s < 3; s++) begin
      k = (s == 0) ? 1 : ((s == 1) ? 3 : 4);
      lat = int'(LATS[k]);
      do_reset();
      for (int t = 0; t <= lat; t++) begin
        i_req = (t == 0); i_addr = 32'h4000;
        d_req = (t > 0); d_we = 0; d_addr = 32'h5000;
        mem_rdata = 32'h600 + 32'(t);
        @(negedge clk);
        chk($sformatf("lat%0d_t%0d", lat, t),
            134'({i_gnt_a[k], d_gnt_a[k], i_rvalid_a[k], d_rvalid_a[k], i_rdata_a[k]}),
            134'({t == 0, t == lat, t == lat, 1'b0, (t == lat) ? mem_rdata : 32'h0}));
        tick();
      end
      d_req = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
